// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the in-order issue stage: opcode encodings,
// instruction field positions and per-opcode operand-usage helpers.
package issue_scoreboard_pkg;

    localparam logic [2:0] OPNOP  = 3'b000;
    localparam logic [2:0] OPADD  = 3'b001;
    localparam logic [2:0] OPMUL  = 3'b010;
    localparam logic [2:0] OPADDI = 3'b011;

    localparam int REG_AW  = 5;
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 2;
    localparam int RS1_LSB = 3;
    localparam int RS1_MSB = 7;
    localparam int RD_LSB  = 8;
    localparam int RD_MSB  = 12;
    localparam int RS2_LSB = 13;
    localparam int RS2_MSB = 17;
    localparam int IMM_LSB = 13;
    localparam int IMM_MSB = 24;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        logic        valid;
        logic [2:0]  opcode;
        reg_idx_t    rs1;
        reg_idx_t    rs2;
        reg_idx_t    rd;
        logic [11:0] imm;
        logic        illegal;
    } issue_out_t;

    function automatic logic is_illegal(input logic [2:0] opcode);
        return opcode > OPADDI;
    endfunction

    function automatic logic reads_rs1(input logic [2:0] opcode);
        return (opcode == OPADD) || (opcode == OPMUL) || (opcode == OPADDI);
    endfunction

    function automatic logic reads_rs2(input logic [2:0] opcode);
        return (opcode == OPADD) || (opcode == OPMUL);
    endfunction

    function automatic logic writes_rd(input logic [2:0] opcode);
        return (opcode == OPADD) || (opcode == OPMUL) || (opcode == OPADDI);
    endfunction

endpackage

// File: rtl/issue_busy_tbl.sv
// Per-register busy scoreboard: one HOLD-cycle down-counter per register
// 1..NREG-1; register 0 is never tracked and always reads as not busy.
module issue_busy_tbl
    import issue_scoreboard_pkg::*;
#(
    parameter int HOLD = 5,
    parameter int NREG = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t rd_addr_a_i,
    input  reg_idx_t rd_addr_b_i,
    input  logic     load_en_i,
    input  reg_idx_t load_addr_i,
    output logic     busy_a_o,
    output logic     busy_b_o
);

    localparam int CW = $clog2(HOLD + 1);

    logic [NREG-1:0] busy_vec;

    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
        always_comb begin
            cnt_d = cnt_q;
            if (load_en_i && (load_addr_i == REG_AW'(r))) begin
                cnt_d = CW'(HOLD);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        // NOTE: the counters are reset like any other state: a stale count would stall issue after reset.
        // NOTE: sequential state uses <= so every counter samples the pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign busy_vec[r] = (cnt_q != '0);
    end

    assign busy_a_o = busy_vec[rd_addr_a_i];
    assign busy_b_o = busy_vec[rd_addr_b_i];

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue stage: decode, RAW hazard check against the busy table, and
// registered issue outputs. Optional counters are enabled by ISSUE_STATS_EN.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int HOLD  = 5,
    parameter int NREG  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] ins,
    output logic        in_ready,
    output logic        out_valid,
    output logic [2:0]  out_opcode,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [11:0] out_imm,
    output logic        illegal
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] issue_cnt
`endif
);

    logic [2:0]  opcode;
    reg_idx_t    rs1;
    reg_idx_t    rs2;
    reg_idx_t    rd;
    logic [11:0] imm;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        hazard;
    logic        accept;
    logic        load_en;
    issue_out_t  out_q;
    issue_out_t  out_d;

    // WIDTH describes the downstream datapath only; bits above imm are reserved.
    logic [WIDTH-1:0] unused_width;
    logic             unused_ins_hi;
    assign unused_width  = '0;
    assign unused_ins_hi = ^ins[31:IMM_MSB+1];

    assign opcode = ins[OPC_MSB:OPC_LSB];
    assign rs1    = ins[RS1_MSB:RS1_LSB];
    assign rd     = ins[RD_MSB:RD_LSB];
    assign rs2    = ins[RS2_MSB:RS2_LSB];
    assign imm    = ins[IMM_MSB:IMM_LSB];

    issue_busy_tbl #(
        .HOLD (HOLD),
        .NREG (NREG)
    ) u_busy_tbl (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_a_i (rs1),
        .rd_addr_b_i (rs2),
        .load_en_i   (load_en),
        .load_addr_i (rd),
        .busy_a_o    (busy_rs1),
        .busy_b_o    (busy_rs2)
    );

    // Register 0 reads as never busy, and the read precedes the write, so
    // self-dependence needs no special case.
    assign hazard = in_valid && !is_illegal(opcode) &&
                    ((reads_rs1(opcode) && busy_rs1) || (reads_rs2(opcode) && busy_rs2));
    assign in_ready = rst || !hazard;
    assign accept   = in_valid && !hazard;
    assign load_en  = accept && writes_rd(opcode) && (rd != '0);

    always_comb begin
        out_d = '0;
        if (accept) begin
            out_d.valid = 1'b1;
            if (is_illegal(opcode)) begin
                out_d.illegal = 1'b1;
            end else begin
                out_d.opcode = opcode;
                out_d.rs1    = rs1;
                out_d.rs2    = rs2;
                out_d.rd     = rd;
                out_d.imm    = imm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_valid  = out_q.valid;
    assign out_opcode = out_q.opcode;
    assign out_rs1    = out_q.rs1;
    assign out_rs2    = out_q.rs2;
    assign out_rd     = out_q.rd;
    assign out_imm    = out_q.imm;
    assign illegal    = out_q.illegal;

`ifdef ISSUE_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;
    logic [31:0] issue_q;
    logic [31:0] issue_d;

    always_comb begin
        stall_d = stall_q;
        issue_d = issue_q;
        if (hazard) begin
            stall_d = stall_q + 32'd1;
        end
        if (accept) begin
            issue_d = issue_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            issue_q <= '0;
        end else begin
            stall_q <= stall_d;
            issue_q <= issue_d;
        end
    end

    assign stall_cnt = stall_q;
    assign issue_cnt = issue_q;
`endif

endmodule
